// File: rtl/cpu_mc_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mc_pkg
// Shared definitions for the multi-cycle processor core:
//   - opcode constants (OP [31:24] of the 32-bit instruction word)
//   - FSM state encoding
//   - ALU operation select and branch condition select codes
//   - clog2 helper used for register address widths
// The shift opcodes are defined here unconditionally. They are only decoded as
// legal when the core is built with CPU_SHIFT_EN.
// -----------------------------------------------------------------------------
package cpu_mc_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_SLL   = 8'h09;
    localparam logic [7:0] OP_SRL   = 8'h0A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ALU_IMM  = 4'd0,   // pass sign-extended immediate
        ALU_MOVB = 4'd1,   // pass operand B
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_NOP  = 4'd8    // branches and jumps: no result used
    } alu_sel_e;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_ALWAYS = 2'd1,
        BR_EQ     = 2'd2,
        BR_NE     = 2'd3
    } br_sel_e;

    // Smallest n with 2**n >= value (value >= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_regfile_p.sv
// -----------------------------------------------------------------------------
// cpu_regfile_p
// General register file for cpu_mc_core.
//   CLK       in   clock, rising edge
//   RESET     in   asynchronous active-low clear of every register
//   rd1_addr  in   read port 1 address   -> rd1_data (combinational)
//   rd2_addr  in   read port 2 address   -> rd2_data (combinational)
//   dbg_addr  in   debug read address    -> dbg_data (combinational)
//   wr_en     in   write enable, sampled on rising CLK
//   wr_addr   in   write address
//   wr_data   in   write data
// -----------------------------------------------------------------------------
module cpu_regfile_p
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [clog2(REG_COUNT)-1:0] rd1_addr,
    output logic [DATA_W-1:0]           rd1_data,
    input  logic [clog2(REG_COUNT)-1:0] rd2_addr,
    output logic [DATA_W-1:0]           rd2_data,
    input  logic [clog2(REG_COUNT)-1:0] dbg_addr,
    output logic [DATA_W-1:0]           dbg_data,
    input  logic                        wr_en,
    input  logic [clog2(REG_COUNT)-1:0] wr_addr,
    input  logic [DATA_W-1:0]           wr_data
);

    logic [DATA_W-1:0] regs_r [REG_COUNT];

    // Register storage: cleared on reset, single synchronous write port.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // REG_COUNT is a power of two, so every address is in range.
    assign rd1_data = regs_r[rd1_addr];
    assign rd2_data = regs_r[rd2_addr];
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/cpu_mc_core.sv
// -----------------------------------------------------------------------------
// cpu_mc_core
// Multi-cycle processor core: FETCH -> DECODE -> EXEC -> WB, plus a terminal
// HALT state entered on an illegal opcode (left only through RESET).
// Instruction word: OP[31:24] DEST/OFFSET[23:16] RS1[15:8] RS2/IMM[7:0].
//
// Ports:
//   CLK            in   clock, rising edge
//   RESET          in   asynchronous active-low reset
//   PC             out  current instruction address
//   IMEM_READ      out  instruction read request
//   IMEM_BUSYWAIT  in   high while INSTRUCTION is not yet valid
//   INSTRUCTION    in   fetched instruction word
//   RETIRED        out  one-cycle pulse after an instruction completes
//   HALTED         out  high after an illegal opcode until reset
//   DBG_ADDR       in   debug register select
//   DBG_DATA       out  combinational read of register DBG_ADDR
//
// Build option: CPU_SHIFT_EN enables opcodes 0x09 (sll) and 0x0A (srl);
// without it those opcodes halt the core.
// -----------------------------------------------------------------------------
module cpu_mc_core
    import cpu_mc_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          REG_COUNT = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                        CLK,
    input  logic                        RESET,
    output logic [31:0]                 PC,
    output logic                        IMEM_READ,
    input  logic                        IMEM_BUSYWAIT,
    input  logic [31:0]                 INSTRUCTION,
    output logic                        RETIRED,
    output logic                        HALTED,
    input  logic [clog2(REG_COUNT)-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]           DBG_DATA
);

    localparam int RA_W = clog2(REG_COUNT);

    state_e            state_r;
    state_e            state_s;
    logic [31:0]       pc_r;
    logic [31:0]       ir_r;
    logic              imem_read_r;
    logic              retired_r;
    logic              halted_r;

    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic [DATA_W-1:0] imm_r;
    alu_sel_e          alu_sel_r;
    br_sel_e           br_sel_r;
    logic              wen_r;

    logic [DATA_W-1:0] result_r;
    logic              taken_r;
    logic [31:0]       target_r;

    logic [RA_W-1:0]   rs1_s;
    logic [RA_W-1:0]   rs2_s;
    logic [RA_W-1:0]   dest_s;
    logic [DATA_W-1:0] rd1_data_s;
    logic [DATA_W-1:0] rd2_data_s;
    logic [DATA_W-1:0] imm_s;
    logic              fetch_ok_s;
    logic              rf_wen_s;

    alu_sel_e          dec_alu_s;
    br_sel_e           dec_br_s;
    logic              dec_wen_s;
    logic              dec_legal_s;

    logic [DATA_W-1:0] diff_s;
    logic              zero_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              taken_s;
    logic [31:0]       target_s;
    logic [31:0]       pc_plus4_s;

    // Register fields use only their low RA_W bits; the rest are ignored.
    assign rs1_s  = RA_W'(ir_r[15:8]);
    assign rs2_s  = RA_W'(ir_r[7:0]);
    assign dest_s = RA_W'(ir_r[23:16]);
    assign imm_s  = DATA_W'($signed(ir_r[7:0]));

    // The instruction is only taken once the request has been visible for a cycle.
    assign fetch_ok_s = imem_read_r && !IMEM_BUSYWAIT;
    assign rf_wen_s   = (state_r == ST_WB) && wen_r;
    assign pc_plus4_s = pc_r + 32'd4;

    cpu_regfile_p #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd1_addr (rs1_s),
        .rd1_data (rd1_data_s),
        .rd2_addr (rs2_s),
        .rd2_data (rd2_data_s),
        .dbg_addr (DBG_ADDR),
        .dbg_data (DBG_DATA),
        .wr_en    (rf_wen_s),
        .wr_addr  (dest_s),
        .wr_data  (result_r)
    );

    // Opcode decode into ALU select, branch condition and write enable.
    always_comb begin
        dec_alu_s   = ALU_NOP;
        dec_br_s    = BR_NONE;
        dec_wen_s   = 1'b0;
        dec_legal_s = 1'b1;
        case (ir_r[31:24])
            OP_LOADI: begin dec_alu_s = ALU_IMM;  dec_wen_s = 1'b1; end
            OP_MOV:   begin dec_alu_s = ALU_MOVB; dec_wen_s = 1'b1; end
            OP_ADD:   begin dec_alu_s = ALU_ADD;  dec_wen_s = 1'b1; end
            OP_SUB:   begin dec_alu_s = ALU_SUB;  dec_wen_s = 1'b1; end
            OP_AND:   begin dec_alu_s = ALU_AND;  dec_wen_s = 1'b1; end
            OP_OR:    begin dec_alu_s = ALU_OR;   dec_wen_s = 1'b1; end
            OP_J:     dec_br_s = BR_ALWAYS;
            OP_BEQ:   dec_br_s = BR_EQ;
            OP_BNE:   dec_br_s = BR_NE;
`ifdef CPU_SHIFT_EN
            OP_SLL:   begin dec_alu_s = ALU_SLL;  dec_wen_s = 1'b1; end
            OP_SRL:   begin dec_alu_s = ALU_SRL;  dec_wen_s = 1'b1; end
`endif
            default:  dec_legal_s = 1'b0;
        endcase
    end

    // ALU, zero flag and branch target; all arithmetic wraps at its width.
    always_comb begin
        diff_s    = opa_r - opb_r;
        zero_s    = (diff_s == {DATA_W{1'b0}});
        alu_res_s = {DATA_W{1'b0}};
        case (alu_sel_r)
            ALU_IMM:  alu_res_s = imm_r;
            ALU_MOVB: alu_res_s = opb_r;
            ALU_ADD:  alu_res_s = opa_r + opb_r;
            ALU_SUB:  alu_res_s = diff_s;
            ALU_AND:  alu_res_s = opa_r & opb_r;
            ALU_OR:   alu_res_s = opa_r | opb_r;
`ifdef CPU_SHIFT_EN
            // Shift amount is IMM[4:0]; amounts of DATA_W or more yield zero.
            ALU_SLL:  begin
                if ({1'b0, imm_r[4:0]} >= 6'(DATA_W)) begin
                    alu_res_s = {DATA_W{1'b0}};
                end else begin
                    alu_res_s = opa_r << imm_r[4:0];
                end
            end
            ALU_SRL:  begin
                if ({1'b0, imm_r[4:0]} >= 6'(DATA_W)) begin
                    alu_res_s = {DATA_W{1'b0}};
                end else begin
                    alu_res_s = opa_r >> imm_r[4:0];
                end
            end
`endif
            default:  alu_res_s = {DATA_W{1'b0}};
        endcase
        case (br_sel_r)
            BR_ALWAYS: taken_s = 1'b1;
            BR_EQ:     taken_s = zero_s;
            BR_NE:     taken_s = !zero_s;
            default:   taken_s = 1'b0;
        endcase
        target_s = pc_plus4_s + (32'($signed(ir_r[23:16])) << 5'd2);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (fetch_ok_s) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_legal_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_EXEC:  state_s = ST_WB;
            ST_WB:    state_s = ST_FETCH;
            ST_HALT:  state_s = ST_HALT;
            default:  state_s = ST_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_r        <= RESET_PC;
            ir_r        <= 32'h0000_0000;
            imem_read_r <= 1'b0;
            retired_r   <= 1'b0;
            halted_r    <= 1'b0;
            opa_r       <= {DATA_W{1'b0}};
            opb_r       <= {DATA_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            alu_sel_r   <= ALU_NOP;
            br_sel_r    <= BR_NONE;
            wen_r       <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            taken_r     <= 1'b0;
            target_r    <= 32'h0000_0000;
        end else begin
            // Request stays up for as long as we are (or are about to be) fetching.
            imem_read_r <= (state_s == ST_FETCH);
            retired_r   <= (state_r == ST_WB);
            halted_r    <= (state_s == ST_HALT);
            case (state_r)
                ST_FETCH: begin
                    if (fetch_ok_s) begin
                        ir_r <= INSTRUCTION;
                    end
                end
                ST_DECODE: begin
                    opa_r     <= rd1_data_s;
                    opb_r     <= rd2_data_s;
                    imm_r     <= imm_s;
                    alu_sel_r <= dec_alu_s;
                    br_sel_r  <= dec_br_s;
                    wen_r     <= dec_wen_s;
                end
                ST_EXEC: begin
                    result_r <= alu_res_s;
                    taken_r  <= taken_s;
                    target_r <= target_s;
                end
                ST_WB: begin
                    if (taken_r) begin
                        pc_r <= target_r;
                    end else begin
                        pc_r <= pc_plus4_s;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign PC        = pc_r;
    assign IMEM_READ = imem_read_r;
    assign RETIRED   = retired_r;
    assign HALTED    = halted_r;

endmodule

// File: doc/cpu_mc_core.md
Name: cpu_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle simple processor core.
- Same 32-bit instruction format:
  - OP [31:24]
  - DEST/OFFSET [23:16]
  - RS1 [15:8]
  - RS2/IMM [7:0]
- Generalised data width and register count.
- Fetches through an instruction-memory handshake that stalls on busywait, adds bne, and halts on illegal opcodes.
- Sits between the testbench/instruction memory and (later) a data-memory port.

Parameters:
- DATA_W, 8, width of registers, ALU and immediate path (8..32).
- REG_COUNT, 8, number of general registers (power of 2, 2..256); address width RA_W = clog2(REG_COUNT), taken from the low bits of each register field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  out  32  current instruction address.
- IMEM_READ  out  1  instruction read request.
- IMEM_BUSYWAIT  in  1  high while INSTRUCTION is not yet valid.
- INSTRUCTION  in  32  fetched instruction, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
- RETIRED  out  1  one-cycle pulse when an instruction completes.
- HALTED  out  1  high after an illegal opcode until reset.
- DBG_ADDR  in  RA_W  debug register select.
- DBG_DATA  out  DATA_W  combinational read of register DBG_ADDR.

Behaviour:
- Reset (RESET=0, async):
  - PC=RESET_PC; all registers 0; state=FETCH.
  - IMEM_READ=0, RETIRED=0, HALTED=0, IR=0.
  - First IMEM_READ asserts on the first rising edge after RESET deasserts.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - Assert IMEM_READ.
  - Each edge with IMEM_BUSYWAIT=0: latch IR<=INSTRUCTION, drop IMEM_READ, go to DECODE.
  - IMEM_BUSYWAIT held high: stay indefinitely; PC stable.
- DECODE:
  - Latch OPA=R[RS1], OPB=R[RS2].
  - Immediate = sign-extended IMM[7:0] to DATA_W; for DATA_W=8 use as is.
  - Unknown opcode -> HALT.
- EXEC:
  - RESULT computed modulo 2^DATA_W.
  - ZERO=(OPA-OPB==0), computed with DATA_W-bit two's complement subtraction.
  - Branch target = PC+4 + (sext32(OFFSET)<<2), 32-bit wrap-around.
- WB:
  - Write R[DEST] for register-writing ops.
  - PC <= target if taken, else PC+4.
  - Pulse RETIRED for one cycle; go to FETCH.
- Opcodes:
  - 0x00 loadi: R[d]=imm.
  - 0x01 mov: R[d]=R[rs2].
  - 0x02 add: R[rs1]+R[rs2].
  - 0x03 sub: R[rs1]-R[rs2].
  - 0x04 and.
  - 0x05 or.
  - 0x06 j: always taken, no write.
  - 0x07 beq: taken if ZERO, no write.
  - 0x08 bne: taken if !ZERO, no write.
- Latency: 4 cycles per instruction with zero-wait memory, plus one cycle per busywait cycle.
- HALT:
  - HALTED=1, IMEM_READ=0, no further register or PC change.
  - Exit only via reset.
  - PC holds the address of the illegal instruction.
- Register-index bits above RA_W are ignored.
- Writing the register a later instruction reads is always visible: no hazards, since execution is sequential.
- Reset mid-operation: aborts the instruction with no write and no RETIRED pulse.
- DBG_DATA reflects a write on the cycle after WB.

Optional Feature:
- Macro: CPU_SHIFT_EN.
- Defined: adds opcode 0x09 sll, R[d]=R[rs1]<<IMM[4:0], and 0x0A srl, logical right shift. Shift amounts >= DATA_W give 0.
- Undefined: 0x09/0x0A are illegal and enter HALT.

Decomposition:
- Package cpu_mc_pkg holds:
  - opcode constants;
  - FSM state encoding;
  - ALU select codes;
  - a clog2 function.
- One sub-module: cpu_regfile_p, parametrised DATA_W/REG_COUNT.
  - Two async read ports plus a debug read port.
  - One synchronous write port.
  - Async active-low clear.
- ALU stays inline in the core.

Test Plan:
- Reset then loadi r1,5; loadi r2,3; add r3,r1,r2 -> DBG r3=8; RETIRED pulses every 4 cycles; PC 0,4,8,12.
- sub r4,r2,r1 with DATA_W=8 -> r4=0xFE; with DATA_W=16 and loadi r1,-2 -> r1=0xFFFE (sign extension).
- beq r1,r1 offset -2 at PC=16 -> next PC=12; bne with equal operands -> PC=20; j offset 0x7F from PC=0 -> PC=0x200.
- IMEM_BUSYWAIT high 5 cycles during fetch -> IMEM_READ held, PC unchanged; instruction retires 9 cycles after fetch start.
- Opcode 0xFF at PC=8 -> HALTED=1 after DECODE, PC stays 8, registers unchanged; RESET low -> all cleared.
- RESET asserted during EXEC of add r3 -> r3 stays 0, no RETIRED; with CPU_SHIFT_EN, sll r5,r1,#2 where r1=5 -> r5=20.
